uart_rx_mmio: RTL and testbench

- 8N1 UART receiver with a small first-word-fall-through (FWFT) receive FIFO.
- Sits on the SOC's ftdi_rxd pin, upstream of the CPU IO read mux.
- The SOC maps rx_data / status into the IO page alongside LEDs and UART transmit.
- CPU polls rx_valid and pops bytes with a read strobe.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rx_fifo.sv | 53 +++++
 rtl/uart_rx_mmio.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and the baud divisor helper
// used by both receive and transmit so they round the same way.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through FIFO; the head entry is visible on rdata whenever
// the FIFO is not empty.
module rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are meaningful, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Gate the head so the output reads zero, not stale storage, when empty.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver feeding a small FWFT FIFO that the CPU polls and pops,
// with sticky overrun and framing-error flags.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_rx,
    input  logic                          i_pop,
    input  logic                          i_err_clear,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overrun,
    output logic                          o_frame_err
);
    localparam int DIV  = int'(calc_div(CLK_FREQ_HZ, BAUD_RATE));
    localparam int HALF = DIV / 2;

    if (DIV < 4 || DIV > 65535) begin : g_bad_div
        $error("uart_rx_mmio: clocks per bit must be in 4..65535");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_mmio: FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic        rx_meta;
    logic        rx_s;
    logic        rx_prev;

    rx_state_t   state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        push;
    logic        frame_set;
    logic        tick;

    logic        fifo_full;
    logic        fifo_empty;
    logic        drop;

    // Synchronizer idles high so reset never looks like a start edge.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    assign tick = (cnt == '0);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        push      = 1'b0;
        frame_set = 1'b0;

        unique case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_n = START;
                    cnt_n   = 16'(HALF - 1);
                end
            end
            START: begin
                if (!tick) begin
                    cnt_n = cnt - 16'd1;
                end else if (rx_s) begin
                    state_n = IDLE;
                end else begin
                    state_n   = DATA;
                    cnt_n     = 16'(DIV - 1);
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    shreg_n = {rx_s, shreg[7:1]};
                    cnt_n   = 16'(DIV - 1);
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_n = cnt - 16'd1;
                end else if (rx_s) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end else begin
                    frame_set = 1'b1;
                    state_n   = BREAK;
                end
            end
            BREAK: begin
                // Hold here until the line idles so a stuck-low line reports once.
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (shreg),
        .pop    (i_pop),
        .rdata  (o_data),
        .count  (o_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign o_valid = !fifo_empty;
    assign drop    = fifo_full && push && !i_pop;

    // A flag being set in the same cycle as a clear stays set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_overrun   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_overrun   <= (o_overrun   && !i_err_clear) || drop;
            o_frame_err <= (o_frame_err && !i_err_clear) || frame_set;
        end
    end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio at default parameters: exact push latency,
// glitch rejection, FIFO full/empty corners, error flags and async reset.
module tb_uart_rx_mmio;

    localparam int DIV        = 217;
    localparam int HALF       = 108;
    localparam int SAMPLE_OFS = HALF + 2;   // stop-sample cycle offset into the stop bit
    localparam int FRAME      = 10 * DIV;

    logic       clk = 1'b0;
    logic       resetn;
    logic       i_rx;
    logic       i_pop;
    logic       i_err_clear;
    logic [7:0] o_data;
    logic       o_valid;
    logic [2:0] o_count;
    logic       o_overrun;
    logic       o_frame_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic [2:0] exp_count;
        logic       exp_overrun;
    } push_vec_t;

    push_vec_t  pv [5];
    logic [7:0] exp_pop [4];

    uart_rx_mmio dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_rx        (i_rx),
        .i_pop       (i_pop),
        .i_err_clear (i_err_clear),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_count     (o_count),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting just after a clock edge. Optional strobes land
    // in the stop-sample cycle; chk_lat expects an empty FIFO beforehand.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic pop_at, input logic clr_at,
                              input logic chk_lat, input logic [7:0] exp_head);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int k = 0; k < 9; k++) begin
            i_rx = bits[k];
            tick(DIV);
        end
        i_rx = stop_bit;
        for (int c = 0; c < DIV; c++) begin
            if (c == SAMPLE_OFS) begin
                if (chk_lat) check("lat_before_push", o_valid, 1'b0);
                i_pop       = pop_at;
                i_err_clear = clr_at;
            end
            if (c == SAMPLE_OFS + 1) begin
                i_pop       = 1'b0;
                i_err_clear = 1'b0;
                if (chk_lat) begin
                    check("lat_valid", o_valid, 1'b1);
                    check("lat_data", o_data, exp_head);
                end
            end
            tick(1);
        end
        i_rx = 1'b1;
    endtask

    task automatic pop_byte(input logic [7:0] exp);
        check("pop_valid", o_valid, 1'b1);
        check("pop_data", o_data, exp);
        i_pop = 1'b1;
        tick(1);
        i_pop = 1'b0;
    endtask

    task automatic pulse_clear();
        i_err_clear = 1'b1;
        tick(1);
        i_err_clear = 1'b0;
    endtask

    initial begin
        pv[0] = '{8'h00, 3'd1, 1'b0};
        pv[1] = '{8'hFF, 3'd2, 1'b0};
        pv[2] = '{8'h55, 3'd3, 1'b0};
        pv[3] = '{8'h81, 3'd4, 1'b0};
        pv[4] = '{8'h42, 3'd4, 1'b1};
        exp_pop[0] = 8'h00;
        exp_pop[1] = 8'hFF;
        exp_pop[2] = 8'h55;
        exp_pop[3] = 8'h81;

        resetn = 1'b0; i_rx = 1'b1; i_pop = 1'b0; i_err_clear = 1'b0;
        tick(3);
        check("rst_valid", o_valid, 1'b0);
        check("rst_count", o_count, 3'd0);
        check("rst_data", o_data, 8'h00);
        check("rst_overrun", o_overrun, 1'b0);
        check("rst_frame_err", o_frame_err, 1'b0);
        resetn = 1'b1;
        tick(5);

        // Single byte with exact latency.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
        check("a5_count", o_count, 3'd1);
        pop_byte(8'hA5);
        check("a5_empty_valid", o_valid, 1'b0);
        check("a5_empty_count", o_count, 3'd0);

        // Pop while empty is ignored.
        i_pop = 1'b1;
        tick(1);
        i_pop = 1'b0;
        check("pop_empty_count", o_count, 3'd0);
        check("pop_empty_valid", o_valid, 1'b0);
        check("pop_empty_overrun", o_overrun, 1'b0);

        // Short low glitch is rejected.
        i_rx = 1'b0;
        tick(50);
        i_rx = 1'b1;
        tick(300);
        check("glitch_valid", o_valid, 1'b0);
        check("glitch_frame_err", o_frame_err, 1'b0);
        check("glitch_overrun", o_overrun, 1'b0);

        // Push with a simultaneous pop on an empty FIFO: the push wins.
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("3c_count", o_count, 3'd1);
        pop_byte(8'h3C);

        // Fill past depth with no pops.
        for (int i = 0; i < 5; i++) begin
            send_frame(pv[i].data, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            check("fill_count", o_count, pv[i].exp_count);
            check("fill_overrun", o_overrun, pv[i].exp_overrun);
        end
        for (int i = 0; i < 4; i++) pop_byte(exp_pop[i]);
        check("drain_valid", o_valid, 1'b0);
        pulse_clear();
        check("clear_overrun", o_overrun, 1'b0);

        // Full FIFO with a pop in the push cycle: no overrun.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("full_count", o_count, 3'd4);
        send_frame(8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("full_pop_count", o_count, 3'd4);
        check("full_pop_overrun", o_overrun, 1'b0);
        pop_byte(8'h22);
        pop_byte(8'h33);
        pop_byte(8'h44);
        pop_byte(8'h7E);
        check("full_pop_drained", o_valid, 1'b0);

        // Low stop bit; a clear in the same cycle loses to the set.
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick(20);
        check("ferr_set", o_frame_err, 1'b1);
        check("ferr_no_push", o_count, 3'd0);
        check("ferr_no_overrun", o_overrun, 1'b0);
        pulse_clear();
        check("ferr_cleared", o_frame_err, 1'b0);

        // Line held low for three frame times reports a single error.
        i_rx = 1'b0;
        tick(FRAME + 200);
        check("break_ferr", o_frame_err, 1'b1);
        pulse_clear();
        tick(2 * FRAME);
        check("break_once", o_frame_err, 1'b0);
        check("break_no_push", o_count, 3'd0);
        i_rx = 1'b1;
        tick(50);
        check("break_release_ferr", o_frame_err, 1'b0);
        check("break_release_count", o_count, 3'd0);

        // Async reset in the middle of bit 4 with two bytes queued.
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("prerst_count", o_count, 3'd2);
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h99, 1'b0};
            for (int k = 0; k < 5; k++) begin
                i_rx = bits[k];
                tick(DIV);
            end
            i_rx = bits[5];
            tick(DIV / 2);
        end
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_count", o_count, 3'd0);
        check("midrst_data", o_data, 8'h00);
        check("midrst_overrun", o_overrun, 1'b0);
        check("midrst_frame_err", o_frame_err, 1'b0);
        i_rx = 1'b1;
        tick(5);
        resetn = 1'b1;
        tick(10);
        check("postrst_count", o_count, 3'd0);
        send_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66);
        check("postrst_only_one", o_count, 3'd1);
        pop_byte(8'h66);
        check("postrst_empty", o_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
